// File: rtl/cpu_pkg.sv
// Types shared by the ID/EX and EX/MEM registers: width defaults, the redirect
// FSM encoding and the control bundle.
package cpu_pkg;

   localparam int DEF_DATA_W       = 32;
   localparam int DEF_REG_AW       = 6;
   localparam int DEF_FLUSH_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_JMEM_WAIT = 2'b01,
      ST_FLUSH     = 2'b10
   } redirect_state_t;

   typedef struct packed {
      logic reg_wrt;
      logic mem_to_reg;
      logic pc_to_reg;
      logic branch_n;
      logic branch_z;
      logic jump;
      logic jump_mem;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   // Branch/jump decision on the raw incoming bundle (JumpMem is handled apart).
   function automatic logic is_taken(ctrl_t c, logic z, logic n);
      return (c.branch_z & z) | (c.branch_n & n) | c.jump;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM bundle: control and datapath from ID/EX in, registered values and
// PC redirect out. master = upstream/driver side, slave = the EX/MEM stage.
interface ex_mem_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
);
   logic              stall;
   logic              RegWrtIn, memToRegIn, PCtoRegIn, memReadIn, memWriteIn;
   logic              BranchNIn, BranchZIn, JumpIn, JumpMemIn;
   logic [DATA_W-1:0] alu_result_in;
   logic              alu_z_in, alu_n_in;
   logic [DATA_W-1:0] store_data_in;
   logic [DATA_W-1:0] target_in;
   logic [DATA_W-1:0] pc_in;
   logic [REG_AW-1:0] rd_in;
   logic [DATA_W-1:0] mem_rdata;

   logic              RegWrtOut, MemtoRegOut, PCtoRegOut, memReadOut, memWriteOut;
   logic [DATA_W-1:0] alu_result_out, store_data_out, pc_out;
   logic [REG_AW-1:0] rd_out;
   logic              pc_sel;
   logic [DATA_W-1:0] pc_target;
   logic              flush;

   modport master (
      output stall, RegWrtIn, memToRegIn, PCtoRegIn, memReadIn, memWriteIn,
             BranchNIn, BranchZIn, JumpIn, JumpMemIn, alu_result_in, alu_z_in,
             alu_n_in, store_data_in, target_in, pc_in, rd_in, mem_rdata,
      input  RegWrtOut, MemtoRegOut, PCtoRegOut, memReadOut, memWriteOut,
             alu_result_out, store_data_out, pc_out, rd_out, pc_sel, pc_target, flush
   );

   modport slave (
      input  stall, RegWrtIn, memToRegIn, PCtoRegIn, memReadIn, memWriteIn,
             BranchNIn, BranchZIn, JumpIn, JumpMemIn, alu_result_in, alu_z_in,
             alu_n_in, store_data_in, target_in, pc_in, rd_in, mem_rdata,
      output RegWrtOut, MemtoRegOut, PCtoRegOut, memReadOut, memWriteOut,
             alu_result_out, store_data_out, pc_out, rd_out, pc_sel, pc_target, flush
   );
endinterface

// File: rtl/ex_mem_stage_redirect_ctrl.sv
// Redirect FSM: flush window counter, pc_sel/pc_target, memory-indirect jump wait.
// Optional perf counters under EXMEM_PERF_CNT_EN.
module redirect_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              taken,
   input  logic              jump_mem,
   input  logic [DATA_W-1:0] target,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              pc_sel,
   output logic [DATA_W-1:0] pc_target,
   output logic              flush
`ifdef EXMEM_PERF_CNT_EN
   ,
   output logic [31:0]       taken_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("redirect_ctrl: FLUSH_CYCLES must be in 1..7");
   end

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   redirect_state_t state;
   logic [2:0]      cnt;
   logic            redirect_now;

   // A redirect fires either from a taken branch/jump in IDLE (JumpMem wins) or
   // when the memory-indirect target arrives.
   assign redirect_now = ((state == ST_IDLE) & ~jump_mem & taken) | (state == ST_JMEM_WAIT);

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pc_sel    <= 1'b0;
         pc_target <= '0;
         flush     <= 1'b0;
      end else if (!stall) begin
         pc_sel <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (jump_mem) begin
                  state <= ST_JMEM_WAIT;
                  flush <= 1'b1;
               end else if (taken) begin
                  state     <= ST_FLUSH;
                  pc_target <= target;
                  pc_sel    <= 1'b1;
                  flush     <= 1'b1;
                  cnt       <= CNT_INIT;
               end
            end
            ST_JMEM_WAIT: begin
               state     <= ST_FLUSH;
               pc_target <= mem_rdata;
               pc_sel    <= 1'b1;
               cnt       <= CNT_INIT;
            end
            ST_FLUSH: begin
               if (cnt == 3'd0) begin
                  state <= ST_IDLE;
                  flush <= 1'b0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               flush <= 1'b0;
            end
         endcase
      end
   end

`ifdef EXMEM_PERF_CNT_EN
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         taken_cnt <= '0;
         flush_cnt <= '0;
      end else if (!stall) begin
         if (redirect_now && taken_cnt != '1) taken_cnt <= taken_cnt + 32'd1;
         if (flush && flush_cnt != '1)        flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   logic unused_redirect;
   assign unused_redirect = redirect_now;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register (negedge capture) with branch/jump redirect and flush.
// Define EXMEM_PERF_CNT_EN to add taken_cnt/flush_cnt outputs.
module ex_mem_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int REG_AW       = DEF_REG_AW,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   ex_mem_if.slave     bus
`ifdef EXMEM_PERF_CNT_EN
   ,
   output logic [31:0] taken_cnt,
   output logic [31:0] flush_cnt
`endif
);

   ctrl_t ctrl_in;
   logic  taken;
   logic  flush;
   logic  jmem_start;

   assign ctrl_in = '{
      reg_wrt:    bus.RegWrtIn,
      mem_to_reg: bus.memToRegIn,
      pc_to_reg:  bus.PCtoRegIn,
      branch_n:   bus.BranchNIn,
      branch_z:   bus.BranchZIn,
      jump:       bus.JumpIn,
      jump_mem:   bus.JumpMemIn,
      mem_read:   bus.memReadIn,
      mem_write:  bus.memWriteIn
   };

   assign taken = is_taken(ctrl_in, bus.alu_z_in, bus.alu_n_in);
   // flush is low only in IDLE, so this is exactly "JumpMem accepted this edge".
   assign jmem_start = ctrl_in.jump_mem & ~flush;
   assign bus.flush  = flush;

   redirect_ctrl #(
      .DATA_W       (DATA_W),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) u_redirect (
      .clk       (clk),
      .rst       (rst),
      .stall     (bus.stall),
      .taken     (taken),
      .jump_mem  (ctrl_in.jump_mem),
      .target    (bus.target_in),
      .mem_rdata (bus.mem_rdata),
      .pc_sel    (bus.pc_sel),
      .pc_target (bus.pc_target),
      .flush     (flush)
`ifdef EXMEM_PERF_CNT_EN
      ,
      .taken_cnt (taken_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   // NOTE: state is written with <= so every register samples pre-edge values.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         bus.RegWrtOut      <= 1'b0;
         bus.MemtoRegOut    <= 1'b0;
         bus.PCtoRegOut     <= 1'b0;
         bus.memReadOut     <= 1'b0;
         bus.memWriteOut    <= 1'b0;
         bus.alu_result_out <= '0;
         bus.store_data_out <= '0;
         bus.pc_out         <= '0;
         bus.rd_out         <= '0;
      end else if (!bus.stall) begin
         bus.RegWrtOut      <= ctrl_in.reg_wrt & ~flush;
         bus.MemtoRegOut    <= ctrl_in.mem_to_reg;
         bus.PCtoRegOut     <= ctrl_in.pc_to_reg;
         bus.memReadOut     <= (ctrl_in.mem_read & ~flush) | jmem_start;
         bus.memWriteOut    <= ctrl_in.mem_write & ~flush;
         bus.alu_result_out <= bus.alu_result_in;
         bus.store_data_out <= bus.store_data_in;
         bus.pc_out         <= bus.pc_in;
         bus.rd_out         <= bus.rd_in;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed test-plan steps, then random
// traffic against a remaining-flush-cycles reference model.
module tb_ex_mem_stage;
   import cpu_pkg::*;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   ex_mem_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

`ifdef EXMEM_PERF_CNT_EN
   logic [31:0] taken_cnt, flush_cnt;
`endif

   ex_mem_stage #(.DATA_W(DW), .REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef EXMEM_PERF_CNT_EN
      ,
      .taken_cnt (taken_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: flush is high while a memory target is pending or while
   // flush cycles remain after a redirect.
   logic          m_regwrt, m_memtoreg, m_pctoreg, m_memread, m_memwrite, m_pc_sel;
   logic [DW-1:0] m_alu, m_store, m_pc, m_target;
   logic [AW-1:0] m_rd;
   int            m_flush_left;
   bit            m_jmem_pending;

   function automatic logic m_flush();
      return m_jmem_pending || (m_flush_left > 0);
   endfunction

   task automatic model_reset();
      {m_regwrt, m_memtoreg, m_pctoreg, m_memread, m_memwrite, m_pc_sel} = '0;
      m_alu = '0; m_store = '0; m_pc = '0; m_target = '0; m_rd = '0;
      m_flush_left = 0;
      m_jmem_pending = 0;
   endtask

   task automatic model_edge();
      logic bub, tk, jm_start;
      if (bus.stall) return;
      bub      = m_flush();
      tk       = (bus.BranchZIn & bus.alu_z_in) | (bus.BranchNIn & bus.alu_n_in) | bus.JumpIn;
      jm_start = bus.JumpMemIn && !bub;
      m_regwrt   = bus.RegWrtIn && !bub;
      m_memtoreg = bus.memToRegIn;
      m_pctoreg  = bus.PCtoRegIn;
      m_memread  = (bus.memReadIn && !bub) || jm_start;
      m_memwrite = bus.memWriteIn && !bub;
      m_alu = bus.alu_result_in; m_store = bus.store_data_in;
      m_pc  = bus.pc_in;         m_rd    = bus.rd_in;
      m_pc_sel = 1'b0;
      if (m_jmem_pending) begin
         m_jmem_pending = 0;
         m_pc_sel       = 1'b1;
         m_target       = bus.mem_rdata;
         m_flush_left   = FC;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (jm_start) begin
         m_jmem_pending = 1;
      end else if (tk) begin
         m_pc_sel     = 1'b1;
         m_target     = bus.target_in;
         m_flush_left = FC;
      end
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".RegWrtOut"},      DW'(bus.RegWrtOut),   DW'(m_regwrt));
      check({tag, ".MemtoRegOut"},    DW'(bus.MemtoRegOut), DW'(m_memtoreg));
      check({tag, ".PCtoRegOut"},     DW'(bus.PCtoRegOut),  DW'(m_pctoreg));
      check({tag, ".memReadOut"},     DW'(bus.memReadOut),  DW'(m_memread));
      check({tag, ".memWriteOut"},    DW'(bus.memWriteOut), DW'(m_memwrite));
      check({tag, ".alu_result_out"}, bus.alu_result_out,   m_alu);
      check({tag, ".store_data_out"}, bus.store_data_out,   m_store);
      check({tag, ".pc_out"},         bus.pc_out,           m_pc);
      check({tag, ".rd_out"},         DW'(bus.rd_out),      DW'(m_rd));
      check({tag, ".pc_sel"},         DW'(bus.pc_sel),      DW'(m_pc_sel));
      check({tag, ".pc_target"},      bus.pc_target,        m_target);
      check({tag, ".flush"},          DW'(bus.flush),       DW'(m_flush()));
   endtask

   task automatic clear_in();
      bus.stall = 0;
      bus.RegWrtIn = 0; bus.memToRegIn = 0; bus.PCtoRegIn = 0;
      bus.memReadIn = 0; bus.memWriteIn = 0;
      bus.BranchNIn = 0; bus.BranchZIn = 0; bus.JumpIn = 0; bus.JumpMemIn = 0;
      bus.alu_result_in = '0; bus.alu_z_in = 0; bus.alu_n_in = 0;
      bus.store_data_in = '0; bus.target_in = '0; bus.pc_in = '0;
      bus.rd_in = '0; bus.mem_rdata = '0;
   endtask

   task automatic rand_in();
      bus.stall         = ($urandom_range(0, 6) == 0);
      bus.RegWrtIn      = 1'($urandom);
      bus.memToRegIn    = 1'($urandom);
      bus.PCtoRegIn     = 1'($urandom);
      bus.memReadIn     = 1'($urandom);
      bus.memWriteIn    = 1'($urandom);
      bus.BranchNIn     = ($urandom_range(0, 3) == 0);
      bus.BranchZIn     = ($urandom_range(0, 3) == 0);
      bus.JumpIn        = ($urandom_range(0, 9) == 0);
      bus.JumpMemIn     = ($urandom_range(0, 9) == 0);
      bus.alu_result_in = $urandom;
      bus.alu_z_in      = 1'($urandom);
      bus.alu_n_in      = 1'($urandom);
      bus.store_data_in = $urandom;
      bus.target_in     = $urandom;
      bus.pc_in         = $urandom;
      bus.rd_in         = AW'($urandom);
      bus.mem_rdata     = $urandom;
   endtask

   // One capture edge: model steps on the pre-edge inputs, DUT sampled 1 ns later.
   task automatic cycle(input string tag);
      model_edge();
      @(negedge clk);
      #1;
      compare_all(tag);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      clear_in();
      model_reset();
      #12;
      compare_all("reset");
      rst = 1'b0;

      // Pass-through
      bus.RegWrtIn = 1; bus.rd_in = 6'd5; bus.alu_result_in = 32'h1234;
      cycle("pass");
      check("pass.RegWrtOut", DW'(bus.RegWrtOut), 32'd1);
      check("pass.rd_out", DW'(bus.rd_out), 32'd5);
      check("pass.alu", bus.alu_result_out, 32'h1234);
      check("pass.pc_sel", DW'(bus.pc_sel), 32'd0);
      check("pass.flush", DW'(bus.flush), 32'd0);

      // Branch Z taken; keep a taken branch at the input to show it is bubbled
      clear_in();
      bus.BranchZIn = 1; bus.alu_z_in = 1; bus.target_in = 32'h40;
      bus.RegWrtIn = 1; bus.memWriteIn = 1;
      cycle("bz0");
      check("bz0.pc_sel", DW'(bus.pc_sel), 32'd1);
      check("bz0.pc_target", bus.pc_target, 32'h40);
      check("bz0.flush", DW'(bus.flush), 32'd1);
      bus.target_in = 32'h99;
      cycle("bz1");
      check("bz1.pc_sel", DW'(bus.pc_sel), 32'd0);
      check("bz1.pc_target", bus.pc_target, 32'h40);
      check("bz1.flush", DW'(bus.flush), 32'd1);
      check("bz1.RegWrtOut", DW'(bus.RegWrtOut), 32'd0);
      check("bz1.memWriteOut", DW'(bus.memWriteOut), 32'd0);
      cycle("bz2");
      check("bz2.flush", DW'(bus.flush), 32'd0);
      check("bz2.pc_sel", DW'(bus.pc_sel), 32'd0);
      check("bz2.RegWrtOut", DW'(bus.RegWrtOut), 32'd0);
      check("bz2.memWriteOut", DW'(bus.memWriteOut), 32'd0);
      bus.BranchZIn = 0;
      cycle("bz3");
      check("bz3.RegWrtOut", DW'(bus.RegWrtOut), 32'd1);

      // Not taken
      clear_in();
      bus.BranchNIn = 1; bus.alu_n_in = 0; bus.alu_z_in = 1; bus.target_in = 32'h77;
      cycle("nt");
      check("nt.pc_sel", DW'(bus.pc_sel), 32'd0);
      check("nt.flush", DW'(bus.flush), 32'd0);

      // JumpMem, with a simultaneous taken branch that must lose
      clear_in();
      bus.JumpMemIn = 1; bus.alu_result_in = 32'h80;
      bus.BranchZIn = 1; bus.alu_z_in = 1; bus.target_in = 32'h55;
      cycle("jm0");
      check("jm0.memReadOut", DW'(bus.memReadOut), 32'd1);
      check("jm0.alu", bus.alu_result_out, 32'h80);
      check("jm0.pc_sel", DW'(bus.pc_sel), 32'd0);
      check("jm0.flush", DW'(bus.flush), 32'd1);
      clear_in();
      bus.mem_rdata = 32'h200;
      cycle("jm1");
      check("jm1.pc_sel", DW'(bus.pc_sel), 32'd1);
      check("jm1.pc_target", bus.pc_target, 32'h200);
      check("jm1.flush", DW'(bus.flush), 32'd1);
      n = 2;
      for (int i = 0; i < 10; i++) begin
         cycle("jm_tail");
         if (bus.flush) n++;
         else break;
      end
      check("jm.flush_span", DW'(n), DW'(1 + FC));

      // Stall mid-FLUSH
      clear_in();
      bus.BranchNIn = 1; bus.alu_n_in = 1; bus.target_in = 32'h300;
      cycle("st0");
      check("st0.pc_sel", DW'(bus.pc_sel), 32'd1);
      bus.BranchNIn = 0; bus.stall = 1; bus.RegWrtIn = 1; bus.alu_result_in = 32'hdead;
      for (int i = 0; i < 3; i++) begin
         cycle("stall");
         check("stall.flush", DW'(bus.flush), 32'd1);
         check("stall.pc_sel", DW'(bus.pc_sel), 32'd1);
         check("stall.pc_target", bus.pc_target, 32'h300);
         check("stall.RegWrtOut", DW'(bus.RegWrtOut), 32'd0);
      end
      bus.stall = 0;
      n = 1;
      for (int i = 0; i < 10; i++) begin
         cycle("st_tail");
         if (bus.flush) n++;
         else break;
      end
      check("stall.flush_span", DW'(n), DW'(FC));

      // Asynchronous reset mid-FLUSH drops the redirect
      clear_in();
      bus.JumpIn = 1; bus.target_in = 32'h500; bus.alu_result_in = 32'h1;
      bus.RegWrtIn = 1; bus.rd_in = 6'd9;
      cycle("rs0");
      check("rs0.flush", DW'(bus.flush), 32'd1);
      clear_in();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("rst_async.flush", DW'(bus.flush), 32'd0);
      check("rst_async.pc_sel", DW'(bus.pc_sel), 32'd0);
      check("rst_async.alu", bus.alu_result_out, 32'd0);
      compare_all("rst_async");
      #3 rst = 1'b0;
      cycle("rs1");
      check("rs1.flush", DW'(bus.flush), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         rand_in();
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register directly downstream of the ID/EX control register; it captures the EX-stage control bundle, ALU result, flags, store data and destination register for the MEM stage.
- Resolves branch and jump decisions and drives the PC redirect (pc_sel/pc_target) and the upstream flush.
- A small FSM handles the multi-cycle flush window and the memory-indirect jump (JumpMem), whose target arrives from data memory one cycle after capture.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, targets)
REG_AW, 6, register-file address width
FLUSH_CYCLES, 2, cycles upstream flush stays asserted after a redirect (1..7)

Ports:
clk  in  1  clock; all state captures on negedge, matching ID/EX
rst  in  1  asynchronous, active-high reset
stall  in  1  hold all pipeline registers (MEM not ready)
RegWrtIn, memToRegIn, PCtoRegIn, memReadIn, memWriteIn  in  1 each  control from ID/EX
BranchNIn, BranchZIn, JumpIn, JumpMemIn  in  1 each  control-flow bits from ID/EX
alu_result_in  in  DATA_W  ALU output
alu_z_in, alu_n_in  in  1 each  ALU zero/negative flags
store_data_in  in  DATA_W  rt value for stores
target_in  in  DATA_W  branch/jump target computed in EX
pc_in  in  DATA_W  PC of the instruction in EX (for PCtoReg)
rd_in  in  REG_AW  destination register
mem_rdata  in  DATA_W  data-memory read data (used for JumpMem target)
RegWrtOut, MemtoRegOut, PCtoRegOut, memReadOut, memWriteOut  out  1 each  registered control to MEM/WB
alu_result_out, store_data_out, pc_out  out  DATA_W each  registered datapath values
rd_out  out  REG_AW  registered destination
pc_sel  out  1  1 = fetch from pc_target this cycle
pc_target  out  DATA_W  redirect address
flush  out  1  squash IF/ID and ID/EX contents

Behaviour:
- Reset (async, immediate): all registered outputs 0; pc_sel=0; flush=0; FSM=IDLE; flush counter=0.
- Capture: on negedge clk with !stall, all *In/datapath inputs are registered, 1-cycle latency. With stall=1, every register and the FSM hold; pc_sel and flush keep their values.
- Bubble: when flush=1 at a capture edge, the captured control bits are forced to 0 (RegWrt, memRead, memWrite, Branch*, Jump*). Datapath registers capture normally but are don't-care.
- taken = (BranchZIn & alu_z_in) | (BranchNIn & alu_n_in) | JumpIn, evaluated on the incoming (non-bubbled) bundle.
- FSM states:
  - IDLE:
    - taken at capture -> FLUSH: pc_target=target_in, pc_sel=1 for one cycle, flush=1, counter=FLUSH_CYCLES-1.
    - JumpMemIn at capture -> JMEM_WAIT: memReadOut forced 1, alu_result_out = address, flush=1.
    - JumpMemIn has priority if both it and taken are asserted.
  - JMEM_WAIT: next unstalled edge latches pc_target=mem_rdata, pc_sel=1 for one cycle, counter=FLUSH_CYCLES-1, -> FLUSH.
  - FLUSH: flush=1; decrement the counter per unstalled edge; at 0 -> IDLE and flush=0. Incoming bundles are bubbled, so no new redirect can start.
- FLUSH_CYCLES=1: FLUSH lasts exactly one cycle.
- Counter is 3 bits. FLUSH_CYCLES outside 1..7 is a configuration error (elaboration assertion).
- PCtoReg: pc_out carries pc_in; WB selects it. No arithmetic here; the EX stage supplies pc+1.
- Reset during FLUSH or JMEM_WAIT: returns to IDLE immediately; the pending redirect is dropped.

Optional Feature:
- Macro EXMEM_PERF_CNT_EN.
- Defined: adds outputs taken_cnt[31:0] and flush_cnt[31:0].
  - taken_cnt increments once per redirect (pc_sel rising).
  - flush_cnt increments per cycle with flush=1 and !stall.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: DATA_W/REG_AW defaults, FSM state encoding (IDLE=2'b00, JMEM_WAIT=2'b01, FLUSH=2'b10), and a ctrl bundle typedef (RegWrt, MemtoReg, PCtoReg, BranchN, BranchZ, Jump, JumpMem, memRead, memWrite) shared with the ID/EX register.
- One sub-module: redirect_ctrl (FSM plus flush counter plus pc_sel/pc_target).

Test Plan:
- Reset: assert rst mid-cycle with registers nonzero -> all outputs 0 asynchronously, before the next clock edge.
- Pass-through: RegWrtIn=1, rd_in=5, alu_result_in=0x1234 -> one negedge later RegWrtOut=1, rd_out=5, alu_result_out=0x1234; pc_sel=0, flush=0.
- Branch Z taken: BranchZIn=1, alu_z_in=1, target_in=0x40, FLUSH_CYCLES=2:
  - pc_sel=1 with pc_target=0x40 for 1 cycle; flush=1 for 2 cycles.
  - The following two bundles are captured with RegWrtOut=0 and memWriteOut=0.
- Not taken: BranchNIn=1, alu_n_in=0 -> no redirect, flush=0.
- JumpMem: JumpMemIn=1, alu_result_in=0x80; next cycle mem_rdata=0x200:
  - memReadOut=1 with address 0x80.
  - Then pc_sel=1 with pc_target=0x200; flush spans JMEM_WAIT plus FLUSH_CYCLES.
- Stall mid-FLUSH: stall=1 for 3 cycles during FLUSH -> counter, flush and outputs frozen; total flush cycles with stall=0 still equals FLUSH_CYCLES.
